// File: rtl/ipd_sequencer.sv
// Control-period scheduler for the I_PD servo loop: period tick, ADC acquisition,
// I_PD enable/settle timing and saturation of the I_PD result into a PWM duty word.
module ipd_sequencer #(
    parameter int N           = 18,
    parameter int CLK_DIV     = 100000,
    parameter int ENA_HOLD    = 4,
    parameter int SETTLE      = 4,
    parameter int ADC_TIMEOUT = 1000,
    parameter int DUTY_W      = 10,
    parameter int DUTY_MAX    = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              adc_start,
    input  logic              adc_done,
    input  logic [N-1:0]      adc_data,
    output logic [N-1:0]      sample_y,
    output logic              ipd_enable,
    input  logic [N-1:0]      ipd_value,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_load,
    output logic              busy,
    output logic              timeout_err,
    output logic              overrun_err,
    input  logic              clear_err,
    output logic [2:0]        fsm_state
);

    localparam int PCNT_W = $clog2(CLK_DIV);
    localparam int WCNT_W = $clog2(ADC_TIMEOUT);
    localparam int PH_MAX = (ENA_HOLD > SETTLE) ? ENA_HOLD : SETTLE;
    localparam int PH_W   = $clog2(PH_MAX);

    localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(CLK_DIV - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST  = WCNT_W'(ADC_TIMEOUT - 1);
    localparam logic [PH_W-1:0]   ENA_LAST   = PH_W'(ENA_HOLD - 1);
    localparam logic [PH_W-1:0]   SET_LAST   = PH_W'(SETTLE - 1);
    localparam logic [N-1:0]      DUTY_MAX_N = N'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DUTY_MAX_D = DUTY_W'(DUTY_MAX);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_ADC_START = 3'd2,
        S_ADC_WAIT  = 3'd3,
        S_ENA_HIGH  = 3'd4,
        S_SETTLE    = 3'd5,
        S_LATCH     = 3'd6
    } state_t;

    state_t              state;
    logic [PCNT_W-1:0]   pcount;
    logic [WCNT_W-1:0]   wait_cnt;
    logic [PH_W-1:0]     phase_cnt;
    logic                tick;
    logic                timeout_hit;
    logic                overrun_hit;
    logic [DUTY_W-1:0]   sat_duty;

    // The period counter free-runs only while run is high; dropping run zeroes it at once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pcount <= '0;
        end else if (!run || tick) begin
            pcount <= '0;
        end else begin
            pcount <= pcount + 1'b1;
        end
    end

    assign tick        = (pcount == PCNT_LAST);
    assign overrun_hit = tick && (state != S_WAIT_TICK);
    assign timeout_hit = (state == S_ADC_WAIT) && !adc_done && (wait_cnt == WCNT_LAST);

    always_comb begin
        sat_duty = ipd_value[DUTY_W-1:0];
        if (ipd_value[N-1]) begin
            sat_duty = '0;
        end else if (ipd_value > DUTY_MAX_N) begin
            sat_duty = DUTY_MAX_D;
        end
    end

    // ADC handshake: adc_start is a one-cycle request; the converter answers later with a
    // one-cycle adc_done strobe carrying adc_data. Only a strobe seen in ADC_WAIT is
    // consumed; strobes in any other state are dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            adc_start   <= 1'b0;
            ipd_enable  <= 1'b0;
            sample_y    <= '0;
            duty        <= '0;
            duty_load   <= 1'b0;
            wait_cnt    <= '0;
            phase_cnt   <= '0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            adc_start <= 1'b0;
            duty_load <= 1'b0;

            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end

            if (overrun_hit) begin
                overrun_err <= 1'b1;
            end else if (clear_err) begin
                overrun_err <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_WAIT_TICK;
                    end
                end
                S_WAIT_TICK: begin
                    if (!run) begin
                        state <= S_IDLE;
                    end else if (tick) begin
                        state     <= S_ADC_START;
                        adc_start <= 1'b1;
                    end
                end
                S_ADC_START: begin
                    state    <= S_ADC_WAIT;
                    wait_cnt <= '0;
                end
                S_ADC_WAIT: begin
                    if (adc_done) begin
                        sample_y   <= adc_data;
                        state      <= S_ENA_HIGH;
                        ipd_enable <= 1'b1;
                        phase_cnt  <= '0;
                    end else if (wait_cnt == WCNT_LAST) begin
                        state <= S_WAIT_TICK;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_ENA_HIGH: begin
                    if (phase_cnt == ENA_LAST) begin
                        ipd_enable <= 1'b0;
                        state      <= S_SETTLE;
                        phase_cnt  <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (phase_cnt == SET_LAST) begin
                        state <= S_LATCH;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_LATCH: begin
                    duty      <= sat_duty;
                    duty_load <= 1'b1;
                    state     <= run ? S_WAIT_TICK : S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE) && (state != S_WAIT_TICK);
    assign fsm_state = state;

endmodule
